zbus_io_master: RTL and testbench
=================================

// Module: zbus_io_master
// PURPOSE
//  Bus initiator for the expansion-board I/O port bus; the requesting end of the port decoder protocol.
//  Turns single-word requests from an internal client (test sequencer, host bridge) into timed
//  Z80-style I/O cycles: address setup, IORQ+RD/WR strobe with wait-state extension, then hold.
//  Samples the responder's decode-claim and read data, and reports done, nack and timeout.
// PARAMETERS
//  SETUP_CYC   1    cycles of address/data setup before strobes assert (>=1)
//  ACTIVE_CYC  2    minimum cycles with strobes asserted (>=1)
//  WAIT_MAX    255  max extra cycles wait_n may stretch ACTIVE before abort (1..255)
// PORTS
//  clk      in   1   system clock; all logic on posedge
//  rst      in   1   asynchronous reset, active high
//  req      in   1   start transaction; sampled only while busy=0
//  rnw      in   1   1=read, 0=write; captured with req
//  addr     in   16  port address; captured with req
//  wdata    in   8   write data; captured with req
//  busy     out  1   transaction in progress
//  done     out  1   one-cycle pulse: transaction finished
//  rdata    out  8   read result; valid from done, held until the next read's done
//  nack     out  1   with done: no responder claimed the port
//  timeout  out  1   with done: wait_n stretch exceeded WAIT_MAX
//  a        out  16  bus address
//  d_out    out  8   bus write data
//  d_oe     out  1   bus data output enable (writes only)
//  d_in     in   8   bus read data
//  iorq_n   out  1   I/O request strobe, active low
//  rd_n     out  1   read strobe, active low
//  wr_n     out  1   write strobe, active low
//  dev_en   in   1   responder claims current address/direction (port decode enable)
//  wait_n   in   1   responder wait request, active low, synchronous to clk
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; iorq_n=rd_n=wr_n=1; d_oe=0; a=0; d_out=0; busy=0;
//   done=0; nack=0; timeout=0; rdata=8'hFF. Reset during a cycle releases strobes immediately.
//  All bus outputs registered; no combinational path from any input to any output.
//  FSM: IDLE -> SETUP -> ACTIVE -> HOLD -> IDLE.
//  IDLE: busy=0. On req=1 latch addr/wdata/rnw; next cycle a=addr, d_out=wdata, d_oe=~rnw, busy=1.
//  SETUP: SETUP_CYC cycles; strobes high, address/data stable.
//  ACTIVE: iorq_n=0 and rd_n=0 (read) or wr_n=0 (write). Counts ACTIVE_CYC cycles. In the last
//   counted cycle, wait_n=0 holds ACTIVE one more cycle; repeat each cycle while wait_n=0.
//   Wait counter is 8 bits, cleared on entering ACTIVE; when it reaches WAIT_MAX with wait_n
//   still 0, abort: go to HOLD with timeout set.
//  End of ACTIVE (the cycle where wait_n=1 is seen, or abort): sample dev_en and d_in.
//   Read: rdata <= (dev_en & ~abort) ? d_in : 8'hFF. Write: rdata unchanged.
//   nack <= ~dev_en; timeout <= abort.
//  HOLD: 1 cycle, strobes high, a/d_out/d_oe unchanged. Then d_oe=0, busy=0, done=1 for one
//   cycle, nack/timeout valid with done and cleared the next cycle; a and d_out keep last value.
//  Latency, defaults, no waits: req seen in cycle 0; SETUP cycle 1; ACTIVE cycles 2-3; HOLD
//   cycle 4; done=1 and busy=0 in cycle 5. Total = SETUP_CYC+ACTIVE_CYC+2 cycles; +1 per wait.
//  Back-to-back: req=1 during the done cycle is accepted (busy=0 there); zero idle gap.
//  req while busy=1 is ignored (not queued); client must hold req until it sees busy.
//  nack and timeout may both be 1; timeout forces rdata=FF regardless of dev_en.
// STRUCTURE
//  Shared package zbus_pkg: FSM state encoding (IDLE,SETUP,ACTIVE,HOLD), OPEN_BUS=8'hFF,
//   strobe level constants; same package used by the port decoder side.
//  One sub-module: zbus_wait_timer (phase counter + 8-bit wait counter, outputs last/abort).
//  Everything else (FSM, capture regs, output regs) in this module.
// TESTING
//  Write addr=16'h80AF wdata=8'h5A, model responder dev_en=1 -> wr_n low cycles 2-3, d_oe=1
//   cycles 1-4, done in cycle 5, nack=0, responder test register reads 8'h5A.
//  Read 16'h01AF then 16'h02AF, responder returns AA/55 with dev_en=1 -> rdata=8'hAA then 8'h55,
//   rd_n low, d_oe never 1, second req in first done cycle starts with no gap.
//  Read 16'h00FE, dev_en=0 -> done cycle 5, nack=1, rdata=8'hFF, timeout=0.
//  Read with wait_n=0 for 3 cycles from last ACTIVE cycle -> ACTIVE lasts 5 cycles, done cycle 8,
//   d_in sampled on the wait_n=1 cycle.
//  WAIT_MAX=4, wait_n stuck 0 -> abort after 4 extra cycles, done with timeout=1, rdata=FF,
//   strobes released, next req accepted normally.
//  Assert rst during ACTIVE of a write -> iorq_n/wr_n=1, d_oe=0, busy=0 same cycle, no done pulse.

Source files
------------

// File: rtl/zbus_pkg.sv
// zbus_pkg
//   Definitions shared by both ends of the expansion-board I/O port bus:
//   - the initiator FSM state encoding,
//   - the open-bus read value,
//   - the active-low strobe levels,
//   - a helper that turns a cycle count into a down-counter load value.
package zbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } zbus_state_e;

  localparam logic [7:0] OPEN_BUS   = 8'hFF;
  localparam logic       STROBE_ON  = 1'b0;
  localparam logic       STROBE_OFF = 1'b1;

  // A phase lasting n cycles loads n-1, so it ends when the counter reaches 0.
  function automatic logic [7:0] cyc_load(input int unsigned n);
    return (n == 0) ? 8'd0 : 8'(n - 1);
  endfunction

endpackage

// File: rtl/zbus_wait_timer.sv
// zbus_wait_timer
//   Phase down-counter plus an 8-bit wait-state counter for the bus initiator.
//   Ports:
//     clk_i, rst_i  clock, async active-high reset
//     load_i        load the phase counter with load_val_i and clear the wait counter
//     load_val_i    phase length minus one
//     active_i      the initiator is in its strobe phase
//     wait_n_i      responder wait request, active low
//     last_o        the phase counter has reached its terminal count
//     abort_o       wait stretch has reached WAIT_MAX while wait_n_i is still low
module zbus_wait_timer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       active_i,
  input  logic       wait_n_i,
  output logic       last_o,
  output logic       abort_o
);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  logic [7:0] phase_q, phase_d;
  logic [7:0] wait_q, wait_d;
  logic       stretch;

  assign last_o  = (phase_q == 8'd0);
  // Waits only count once the minimum strobe time has elapsed.
  assign stretch = active_i & last_o & ~wait_n_i;
  assign abort_o = stretch & (wait_q == WAIT_LIMIT);

  always_comb begin
    phase_d = phase_q;
    wait_d  = wait_q;
    if (load_i) begin
      phase_d = load_val_i;
      wait_d  = 8'd0;
    end else begin
      if (!last_o) phase_d = phase_q - 8'd1;
      if (stretch && !abort_o) wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= 8'd0;
      wait_q  <= 8'd0;
    end else begin
      phase_q <= phase_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: rtl/zbus_io_master.sv
// zbus_io_master
//   Bus initiator for the expansion-board I/O port bus.
//   Turns single-word client requests into Z80-style I/O cycles:
//     SETUP  - address setup,
//     ACTIVE - IORQ plus RD/WR strobe, stretched by wait_n,
//     HOLD   - hold, then a done pulse.
//   Ports:
//     client side : req_i, rnw_i, addr_i, wdata_i -> busy_o, done_o, rdata_o, nack_o, timeout_o
//     bus side    : a_o, d_out_o, d_oe_o, iorq_n_o, rd_n_o, wr_n_o <- d_in_i, dev_en_i, wait_n_i
//   Every output comes straight from a flop.
module zbus_io_master
  import zbus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ACTIVE_CYC = 2,
  parameter int unsigned WAIT_MAX   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        rnw_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic        nack_o,
  output logic        timeout_o,
  output logic [15:0] a_o,
  output logic [7:0]  d_out_o,
  output logic        d_oe_o,
  input  logic [7:0]  d_in_i,
  output logic        iorq_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  input  logic        dev_en_i,
  input  logic        wait_n_i
);

  localparam logic [7:0] SETUP_LOAD  = cyc_load(SETUP_CYC);
  localparam logic [7:0] ACTIVE_LOAD = cyc_load(ACTIVE_CYC);

  zbus_state_e state_q, state_d;

  logic        last, abort, accept, end_active;
  logic [15:0] a_q, a_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d, rnw_q, rnw_d;
  logic        iorq_n_q, iorq_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        nack_q, nack_d, timeout_q, timeout_d;
  logic [7:0]  rdata_q, rdata_d;
  // End-of-ACTIVE samples, staged so that the client outputs change only with done.
  logic        nack_s_q, nack_s_d, timeout_s_q, timeout_s_d;
  logic [7:0]  rdata_s_q, rdata_s_d;

  zbus_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (state_q != state_d),
    .load_val_i ((state_d == ST_SETUP) ? SETUP_LOAD : ACTIVE_LOAD),
    .active_i   (state_q == ST_ACTIVE),
    .wait_n_i   (wait_n_i),
    .last_o     (last),
    .abort_o    (abort)
  );

  assign accept     = (state_q == ST_IDLE) & req_i;
  assign end_active = (state_q == ST_ACTIVE) & ((last & wait_n_i) | abort);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)     state_d = ST_SETUP;
      ST_SETUP:  if (last)       state_d = ST_ACTIVE;
      ST_ACTIVE: if (end_active) state_d = ST_HOLD;
      ST_HOLD:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    d_out_d     = d_out_q;
    rnw_d       = rnw_q;
    d_oe_d      = d_oe_q;
    rdata_d     = rdata_q;
    nack_s_d    = nack_s_q;
    timeout_s_d = timeout_s_q;
    rdata_s_d   = rdata_s_q;
    if (accept) begin
      a_d     = addr_i;
      d_out_d = wdata_i;
      rnw_d   = rnw_i;
      d_oe_d  = ~rnw_i;
    end
    if (state_q == ST_HOLD) d_oe_d = 1'b0;
    if (end_active) begin
      nack_s_d    = ~dev_en_i;
      timeout_s_d = abort;
      rdata_s_d   = (dev_en_i && !abort) ? d_in_i : OPEN_BUS;
    end
    if (state_q == ST_HOLD && rnw_q) rdata_d = rdata_s_q;
    // ACTIVE is never entered straight from IDLE, so rnw_q is settled here.
    iorq_n_d  = (state_d == ST_ACTIVE) ? STROBE_ON : STROBE_OFF;
    rd_n_d    = (state_d == ST_ACTIVE && rnw_q)  ? STROBE_ON : STROBE_OFF;
    wr_n_d    = (state_d == ST_ACTIVE && !rnw_q) ? STROBE_ON : STROBE_OFF;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_HOLD);
    nack_d    = (state_q == ST_HOLD) & nack_s_q;
    timeout_d = (state_q == ST_HOLD) & timeout_s_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q         <= 16'd0;
      d_out_q     <= 8'd0;
      rnw_q       <= 1'b1;
      d_oe_q      <= 1'b0;
      iorq_n_q    <= STROBE_OFF;
      rd_n_q      <= STROBE_OFF;
      wr_n_q      <= STROBE_OFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rdata_q     <= OPEN_BUS;
      nack_s_q    <= 1'b0;
      timeout_s_q <= 1'b0;
      rdata_s_q   <= OPEN_BUS;
    end else begin
      a_q         <= a_d;
      d_out_q     <= d_out_d;
      rnw_q       <= rnw_d;
      d_oe_q      <= d_oe_d;
      iorq_n_q    <= iorq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
      timeout_q   <= timeout_d;
      rdata_q     <= rdata_d;
      nack_s_q    <= nack_s_d;
      timeout_s_q <= timeout_s_d;
      rdata_s_q   <= rdata_s_d;
    end
  end

  assign a_o       = a_q;
  assign d_out_o   = d_out_q;
  assign d_oe_o    = d_oe_q;
  assign iorq_n_o  = iorq_n_q;
  assign rd_n_o    = rd_n_q;
  assign wr_n_o    = wr_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign nack_o    = nack_q;
  assign timeout_o = timeout_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_zbus_io_master.sv
module tb_zbus_io_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, rnw = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  wdata = 8'h0, d_in = 8'h0;
  logic        dev_en = 1'b0, wait_n = 1'b1;
  logic        busy, done, nack, timeout, d_oe, iorq_n, rd_n, wr_n;
  logic [7:0]  rdata, d_out;
  logic [15:0] a;

  int passed = 0;
  int total  = 0;

  // Per-cycle traces of one transaction; bit c holds the value seen in cycle c.
  // Strobes are recorded as "asserted" (inverted).
  logic [15:0] tr_busy, tr_done, tr_iorq, tr_rd, tr_wr, tr_doe, tr_nack, tr_to;
  logic [7:0]  tr_rdata [0:15];
  logic [15:0] tr_a [0:15];
  logic [7:0]  tr_dout [0:15];

  // Responder test register: captures write data while it is being strobed.
  logic [7:0] resp_reg = 8'h00;

  zbus_io_master #(.SETUP_CYC(1), .ACTIVE_CYC(2), .WAIT_MAX(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .rnw_i     (rnw),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .busy_o    (busy),
    .done_o    (done),
    .rdata_o   (rdata),
    .nack_o    (nack),
    .timeout_o (timeout),
    .a_o       (a),
    .d_out_o   (d_out),
    .d_oe_o    (d_oe),
    .d_in_i    (d_in),
    .iorq_n_o  (iorq_n),
    .rd_n_o    (rd_n),
    .wr_n_o    (wr_n),
    .dev_en_i  (dev_en),
    .wait_n_i  (wait_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!iorq_n && !wr_n && dev_en) resp_reg <= d_out;

  // Cycle 0 is the cycle in which req is presented. wait_n is held low in
  // cycles [wfrom, wfrom+wlen), and d_in reads 00 in those cycles so that an
  // early sample is visible.
  task automatic run_txn(input logic r, input logic [15:0] ad, input logic [7:0] wd,
                         input logic den, input logic [7:0] din,
                         input int wfrom, input int wlen, input int ncyc);
    logic in_wait;
    tr_busy = '0; tr_done = '0; tr_iorq = '0; tr_rd = '0;
    tr_wr = '0; tr_doe = '0; tr_nack = '0; tr_to = '0;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      tr_busy[c] = busy;     tr_done[c] = done;   tr_iorq[c] = ~iorq_n;
      tr_rd[c]   = ~rd_n;    tr_wr[c]   = ~wr_n;  tr_doe[c]  = d_oe;
      tr_nack[c] = nack;     tr_to[c]   = timeout;
      tr_rdata[c] = rdata;   tr_a[c] = a;         tr_dout[c] = d_out;
      if (c == 0) begin
        req = 1'b1; rnw = r; addr = ad; wdata = wd; dev_en = den;
      end
      if (c == 1) req = 1'b0;
      in_wait = (c >= wfrom) && (c < wfrom + wlen);
      wait_n  = ~in_wait;
      d_in    = in_wait ? 8'h00 : din;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({iorq_n, rd_n, wr_n, d_oe, busy, done, nack, timeout} !== 8'b1110_0000) begin
      $display("FAIL reset_ctrl got=%b exp=11100000",
               {iorq_n, rd_n, wr_n, d_oe, busy, done, nack, timeout});
    end else passed++;
    total++;
    if ({a, d_out} !== 24'h0) begin
      $display("FAIL reset_bus got=%h exp=000000", {a, d_out});
    end else passed++;
    total++;
    if (rdata !== 8'hFF) begin
      $display("FAIL reset_rdata got=%h exp=ff", rdata);
    end else passed++;
  endtask

  task automatic test_write;
    run_txn(1'b0, 16'h80AF, 8'h5A, 1'b1, 8'h33, 0, 0, 6);
    total++;
    if (tr_wr !== 16'h000C) begin
      $display("FAIL wr_wr_n got=%h exp=000c", tr_wr);
    end else passed++;
    total++;
    if (tr_iorq !== 16'h000C || tr_rd !== 16'h0) begin
      $display("FAIL wr_iorq_rd got=%h/%h exp=000c/0000", tr_iorq, tr_rd);
    end else passed++;
    total++;
    if (tr_doe !== 16'h001E) begin
      $display("FAIL wr_d_oe got=%h exp=001e", tr_doe);
    end else passed++;
    total++;
    if (tr_busy !== 16'h001E || tr_done !== 16'h0020) begin
      $display("FAIL wr_busy_done got=%h/%h exp=001e/0020", tr_busy, tr_done);
    end else passed++;
    total++;
    if (tr_nack !== 16'h0 || tr_to !== 16'h0) begin
      $display("FAIL wr_nack_to got=%h/%h exp=0/0", tr_nack, tr_to);
    end else passed++;
    total++;
    if (tr_a[2] !== 16'h80AF || tr_dout[2] !== 8'h5A) begin
      $display("FAIL wr_bus got=%h/%h exp=80af/5a", tr_a[2], tr_dout[2]);
    end else passed++;
    total++;
    if (resp_reg !== 8'h5A) begin
      $display("FAIL wr_resp_reg got=%h exp=5a", resp_reg);
    end else passed++;
    total++;
    if (tr_rdata[5] !== 8'hFF) begin
      $display("FAIL wr_rdata_kept got=%h exp=ff", tr_rdata[5]);
    end else passed++;
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 16'h01AF, 8'h00, 1'b1, 8'hAA, 0, 0, 4);
    total++;
    if (tr_rd !== 16'h000C || tr_doe !== 16'h0) begin
      $display("FAIL b2b1_rd_doe got=%h/%h exp=000c/0000", tr_rd, tr_doe);
    end else passed++;
    total++;
    if (tr_a[2] !== 16'h01AF) begin
      $display("FAIL b2b1_addr got=%h exp=01af", tr_a[2]);
    end else passed++;
    run_txn(1'b1, 16'h02AF, 8'h00, 1'b1, 8'h55, 0, 0, 6);
    total++;
    if (tr_done !== 16'h0021 || tr_busy !== 16'h001E) begin
      $display("FAIL b2b_done_busy got=%h/%h exp=0021/001e", tr_done, tr_busy);
    end else passed++;
    total++;
    if (tr_rdata[0] !== 8'hAA || tr_rdata[4] !== 8'hAA) begin
      $display("FAIL b2b_rdata1 got=%h/%h exp=aa/aa", tr_rdata[0], tr_rdata[4]);
    end else passed++;
    total++;
    if (tr_rdata[5] !== 8'h55) begin
      $display("FAIL b2b_rdata2 got=%h exp=55", tr_rdata[5]);
    end else passed++;
    total++;
    if (tr_rd !== 16'h000C || tr_doe !== 16'h0 || tr_a[2] !== 16'h02AF) begin
      $display("FAIL b2b2_bus got=%h/%h/%h exp=000c/0000/02af", tr_rd, tr_doe, tr_a[2]);
    end else passed++;
  endtask

  task automatic test_nack;
    run_txn(1'b1, 16'h00FE, 8'h00, 1'b0, 8'h12, 0, 0, 6);
    total++;
    if (tr_done !== 16'h0020 || tr_nack !== 16'h0020 || tr_to !== 16'h0) begin
      $display("FAIL nack_flags got=%h/%h/%h exp=0020/0020/0000", tr_done, tr_nack, tr_to);
    end else passed++;
    total++;
    if (tr_rdata[5] !== 8'hFF) begin
      $display("FAIL nack_rdata got=%h exp=ff", tr_rdata[5]);
    end else passed++;
  endtask

  task automatic test_wait;
    run_txn(1'b1, 16'h0042, 8'h00, 1'b1, 8'hC3, 3, 3, 9);
    total++;
    if (tr_rd !== 16'h007C || tr_iorq !== 16'h007C) begin
      $display("FAIL wait_strobe got=%h/%h exp=007c/007c", tr_rd, tr_iorq);
    end else passed++;
    total++;
    if (tr_busy !== 16'h00FE || tr_done !== 16'h0100) begin
      $display("FAIL wait_busy_done got=%h/%h exp=00fe/0100", tr_busy, tr_done);
    end else passed++;
    total++;
    if (tr_rdata[8] !== 8'hC3 || tr_to !== 16'h0) begin
      $display("FAIL wait_rdata got=%h/%h exp=c3/0000", tr_rdata[8], tr_to);
    end else passed++;
  endtask

  task automatic test_timeout;
    run_txn(1'b1, 16'h0077, 8'h00, 1'b1, 8'h77, 3, 100, 10);
    total++;
    if (tr_rd !== 16'h00FC || tr_busy !== 16'h01FE) begin
      $display("FAIL to_strobe_busy got=%h/%h exp=00fc/01fe", tr_rd, tr_busy);
    end else passed++;
    total++;
    if (tr_done !== 16'h0200 || tr_to !== 16'h0200 || tr_nack !== 16'h0) begin
      $display("FAIL to_flags got=%h/%h/%h exp=0200/0200/0000", tr_done, tr_to, tr_nack);
    end else passed++;
    total++;
    if (tr_rdata[9] !== 8'hFF || tr_iorq[9] !== 1'b0) begin
      $display("FAIL to_rdata_release got=%h/%b exp=ff/0", tr_rdata[9], tr_iorq[9]);
    end else passed++;
    run_txn(1'b0, 16'h1234, 8'h3C, 1'b1, 8'h00, 0, 0, 6);
    total++;
    if (tr_done !== 16'h0020 || tr_to !== 16'h0 || tr_wr !== 16'h000C) begin
      $display("FAIL to_next_txn got=%h/%h/%h exp=0020/0000/000c", tr_done, tr_to, tr_wr);
    end else passed++;
    total++;
    if (resp_reg !== 8'h3C) begin
      $display("FAIL to_next_resp got=%h exp=3c", resp_reg);
    end else passed++;
  endtask

  task automatic test_reset_abort;
    logic seen_done;
    @(negedge clk);
    req = 1'b1; rnw = 1'b0; addr = 16'h5555; wdata = 8'hA5; dev_en = 1'b1; wait_n = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    total++;
    if (wr_n !== 1'b0 || iorq_n !== 1'b0) begin
      $display("FAIL rst_pre_active got=%b%b exp=00", iorq_n, wr_n);
    end else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({iorq_n, wr_n, rd_n, d_oe, busy} !== 5'b11100) begin
      $display("FAIL rst_mid_cycle got=%b exp=11100", {iorq_n, wr_n, rd_n, d_oe, busy});
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen_done = seen_done | done | busy;
    end
    total++;
    if (seen_done !== 1'b0) begin
      $display("FAIL rst_no_done got=%b exp=0", seen_done);
    end else passed++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_write;
    test_back_to_back;
    test_nack;
    test_wait;
    test_timeout;
    test_reset_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
